// File: rtl/ibex_mem_intf_arbiter.sv
// Shares one req/gnt/rvalid memory port between NUM_REQ requesters with in-order response routing.
// Build option: define IBEX_MEM_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module ibex_mem_intf_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int INTG_WIDTH      = 7,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_i,
    output logic [NUM_REQ-1:0]                gnt_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     addr_i,
    input  logic [NUM_REQ-1:0]                we_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   be_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     wdata_i,
    input  logic [NUM_REQ*INTG_WIDTH-1:0]     wintg_i,
    output logic [NUM_REQ-1:0]                rvalid_o,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic [INTG_WIDTH-1:0]             rintg_o,
    output logic                              error_o,
    output logic                              out_req_o,
    input  logic                              out_gnt_i,
    output logic [ADDR_WIDTH-1:0]             out_addr_o,
    output logic                              out_we_o,
    output logic [DATA_WIDTH/8-1:0]           out_be_o,
    output logic [DATA_WIDTH-1:0]             out_wdata_o,
    output logic [INTG_WIDTH-1:0]             out_wintg_o,
    input  logic                              out_rvalid_i,
    input  logic [DATA_WIDTH-1:0]             out_rdata_i,
    input  logic [INTG_WIDTH-1:0]             out_rintg_i,
    input  logic                              out_error_i,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
    output logic                              unexpected_rvalid_o
);

    localparam int BEW = DATA_WIDTH / 8;
    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = $clog2(MAX_OUTSTANDING);
    localparam int CW  = PW + 1;

    logic [IDW-1:0] owner_q [MAX_OUTSTANDING];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           lock_q, lock_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic           unexp_q, unexp_d;
    logic [IDW-1:0] arb_id;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] head_id;
    logic           fifo_full, fifo_empty;
    logic           grant, pop;

    assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);

`ifdef IBEX_MEM_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest asserted index is the last to overwrite.
    always_comb begin
        arb_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                arb_id = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW:0]   arb_k;
    logic           arb_found;

    // Search upward from rr_ptr, wrapping at NUM_REQ (which need not be a power of two).
    always_comb begin
        arb_id    = '0;
        arb_k     = '0;
        arb_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_k = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (arb_k >= (IDW+1)'(NUM_REQ)) begin
                arb_k = arb_k - (IDW+1)'(NUM_REQ);
            end
            if (!arb_found && req_i[arb_k[IDW-1:0]]) begin
                arb_found = 1'b1;
                arb_id    = arb_k[IDW-1:0];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign win_id    = lock_q ? lock_id_q : arb_id;
    assign out_req_o = req_i[win_id] & ~fifo_full & ~reset;
    assign grant     = out_req_o & out_gnt_i;
    assign head_id   = owner_q[rd_ptr_q];
    assign pop       = out_rvalid_i & ~fifo_empty & ~reset;

    always_comb begin
        out_addr_o  = '0;
        out_we_o    = 1'b0;
        out_be_o    = '0;
        out_wdata_o = '0;
        out_wintg_o = '0;
        if (out_req_o) begin
            out_addr_o  = addr_i[win_id*ADDR_WIDTH +: ADDR_WIDTH];
            out_we_o    = we_i[win_id];
            out_be_o    = be_i[win_id*BEW +: BEW];
            out_wdata_o = wdata_i[win_id*DATA_WIDTH +: DATA_WIDTH];
            out_wintg_o = wintg_i[win_id*INTG_WIDTH +: INTG_WIDTH];
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign gnt_o[gi]    = grant & (win_id == IDW'(gi));
        assign rvalid_o[gi] = pop & (head_id == IDW'(gi));
    end

    assign rdata_o             = out_rdata_i;
    assign rintg_o             = out_rintg_i;
    assign error_o             = out_error_i;
    assign outstanding_o       = count_q;
    assign unexpected_rvalid_o = unexp_q;

    // A dropped locked request is a withdrawal; a new stall re-locks to whoever is presented.
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (lock_q && !req_i[lock_id_q]) begin
            lock_d = 1'b0;
        end
        if (out_req_o) begin
            lock_d    = ~out_gnt_i;
            lock_id_d = win_id;
        end
    end

    always_comb begin
        wr_ptr_d = grant ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (grant && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!grant && pop) begin
            count_d = count_q - CW'(1);
        end
        unexp_d = unexp_q | (out_rvalid_i & fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            owner_q[wr_ptr_q] <= win_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            unexp_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            unexp_q   <= unexp_d;
        end
    end

endmodule

// File: tb/tb_ibex_mem_intf_arbiter.sv
// Directed bench for ibex_mem_intf_arbiter: scoreboard of expected responses plus cycle checks.
module tb_ibex_mem_intf_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_i;
    logic [1:0]   gnt_o;
    logic [63:0]  addr_i;
    logic [1:0]   we_i;
    logic [7:0]   be_i;
    logic [63:0]  wdata_i;
    logic [13:0]  wintg_i;
    logic [1:0]   rvalid_o;
    logic [31:0]  rdata_o;
    logic [6:0]   rintg_o;
    logic         error_o;
    logic         out_req_o;
    logic         out_gnt_i;
    logic [31:0]  out_addr_o;
    logic         out_we_o;
    logic [3:0]   out_be_o;
    logic [31:0]  out_wdata_o;
    logic [6:0]   out_wintg_o;
    logic         out_rvalid_i;
    logic [31:0]  out_rdata_i;
    logic [6:0]   out_rintg_i;
    logic         out_error_i;
    logic [2:0]   outstanding_o;
    logic         unexpected_rvalid_o;

    ibex_mem_intf_arbiter dut (
        .clk                 (clk),
        .reset               (reset),
        .req_i               (req_i),
        .gnt_o               (gnt_o),
        .addr_i              (addr_i),
        .we_i                (we_i),
        .be_i                (be_i),
        .wdata_i             (wdata_i),
        .wintg_i             (wintg_i),
        .rvalid_o            (rvalid_o),
        .rdata_o             (rdata_o),
        .rintg_o             (rintg_o),
        .error_o             (error_o),
        .out_req_o           (out_req_o),
        .out_gnt_i           (out_gnt_i),
        .out_addr_o          (out_addr_o),
        .out_we_o            (out_we_o),
        .out_be_o            (out_be_o),
        .out_wdata_o         (out_wdata_o),
        .out_wintg_o         (out_wintg_o),
        .out_rvalid_i        (out_rvalid_i),
        .out_rdata_i         (out_rdata_i),
        .out_rintg_i         (out_rintg_i),
        .out_error_i         (out_error_i),
        .outstanding_o       (outstanding_o),
        .unexpected_rvalid_o (unexpected_rvalid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  onehot;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] pend_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        resp_en  = 1'b0;
    logic        inject_rv = 1'b0;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;
    localparam logic [31:0] D0 = 32'h0100_FEFF;  // memory word at A0
    localparam logic [31:0] D1 = 32'h0200_FDFF;  // memory word at A1

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
            $display("check %-16s got=%h ok", name, got);
        end else begin
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input logic [1:0] oh, input logic [31:0] d);
        exp_t e;
        e.onehot = oh;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    // Downstream memory model: records grants, answers one cycle later when enabled.
    always @(negedge clk) begin
        if (out_req_o && out_gnt_i) pend_q.push_back(out_addr_o);
    end

    always begin
        @(posedge clk);
        #1;
        if (inject_rv) begin
            out_rvalid_i = 1'b1;
            out_rdata_i  = 32'hDEAD_BEEF;
            out_rintg_i  = 7'h55;
        end else if (resp_en && pend_q.size() > 0) begin
            logic [31:0] a;
            a = pend_q.pop_front();
            out_rvalid_i = 1'b1;
            out_rdata_i  = mem_word(a);
            out_rintg_i  = a[14:8];
        end else begin
            out_rvalid_i = 1'b0;
            out_rdata_i  = '0;
            out_rintg_i  = '0;
        end
    end

    // Scoreboard monitor: every presented response must match the oldest expectation.
    always @(negedge clk) begin
        if (rvalid_o != 2'b00) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected rvalid_o=%b expected=none", rvalid_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_owner", {30'd0, rvalid_o}, {30'd0, e.onehot});
                check("sb_rdata", rdata_o, e.data);
            end
        end
    end

    initial begin
        reset = 1'b1; req_i = '0; out_gnt_i = 1'b0; out_error_i = 1'b0;
        addr_i  = {A1, A0};
        we_i    = 2'b10;
        be_i    = 8'hF3;
        wdata_i = {32'h2222_2222, 32'h1111_1111};
        wintg_i = {7'h22, 7'h11};
        out_rvalid_i = 1'b0; out_rdata_i = '0; out_rintg_i = '0;
        step(); step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_gnt", {30'd0, gnt_o}, 32'd0);
        check("rst_out_req", {31'd0, out_req_o}, 32'd0);
        check("rst_outstanding", {29'd0, outstanding_o}, 32'd0);
        check("rst_unexpected", {31'd0, unexpected_rvalid_o}, 32'd0);

        // Both requesting, downstream always granting: alternate 0,1,0,1.
        resp_en = 1'b1;
        expect_resp(2'b01, D0); expect_resp(2'b10, D1);
        expect_resp(2'b01, D0); expect_resp(2'b10, D1);
        step(); req_i = 2'b11; out_gnt_i = 1'b1;
        @(negedge clk); check("rr_g0", {30'd0, gnt_o}, 32'd1);
        step(); @(negedge clk); check("rr_g1", {30'd0, gnt_o}, 32'd2);
        step(); @(negedge clk); check("rr_g2", {30'd0, gnt_o}, 32'd1);
        step(); @(negedge clk); check("rr_g3", {30'd0, gnt_o}, 32'd2);
        step(); req_i = 2'b00; out_gnt_i = 1'b0;
        repeat (3) step();

        // Requester 1 stalled 3 cycles; requester 0 joins but cannot steal the lock.
        req_i = 2'b10;
        @(negedge clk);
        check("lock_addr_a", out_addr_o, A1);
        check("lock_wdata", out_wdata_o, 32'h2222_2222);
        check("lock_be", {28'd0, out_be_o}, 32'hF);
        step(); req_i = 2'b11;
        @(negedge clk);
        check("lock_addr_b", out_addr_o, A1);
        check("lock_gnt_b", {30'd0, gnt_o}, 32'd0);
        step(); @(negedge clk); check("lock_addr_c", out_addr_o, A1);
        step(); out_gnt_i = 1'b1; expect_resp(2'b10, D1);
        @(negedge clk);
        check("lock_gnt_d", {30'd0, gnt_o}, 32'd2);
        check("lock_addr_d", out_addr_o, A1);
        step(); expect_resp(2'b01, D0);
        @(negedge clk);
        check("after_lock_gnt", {30'd0, gnt_o}, 32'd1);
        check("after_lock_addr", out_addr_o, A0);
        step(); req_i = 2'b00; out_gnt_i = 1'b0;
        repeat (3) step();

        // Fill the owner FIFO with responses withheld.
        resp_en = 1'b0;
        req_i = 2'b11; out_gnt_i = 1'b1;
        expect_resp(2'b10, D1); expect_resp(2'b01, D0);
        expect_resp(2'b10, D1); expect_resp(2'b01, D0);
        repeat (4) step();
        @(negedge clk);
        check("full_out_req", {31'd0, out_req_o}, 32'd0);
        check("full_outstanding", {29'd0, outstanding_o}, 32'd4);
        resp_en = 1'b1;
        step(); @(negedge clk);
        check("pop_cycle_req", {31'd0, out_req_o}, 32'd0);
        check("pop_cycle_occ", {29'd0, outstanding_o}, 32'd4);
        step(); expect_resp(2'b10, D1);
        @(negedge clk);
        check("resume_occ", {29'd0, outstanding_o}, 32'd3);
        check("resume_gnt", {30'd0, gnt_o}, 32'd2);
        step(); req_i = 2'b00; out_gnt_i = 1'b0;
        repeat (6) step();

        // Simultaneous grant and response at occupancy 2.
        resp_en = 1'b0;
        req_i = 2'b11; out_gnt_i = 1'b1;
        expect_resp(2'b01, D0); expect_resp(2'b10, D1);
        repeat (2) step();
        req_i = 2'b00;
        @(negedge clk);
        check("occ2", {29'd0, outstanding_o}, 32'd2);
        resp_en = 1'b1;
        step(); req_i = 2'b01; expect_resp(2'b01, D0);
        @(negedge clk);
        check("push_pop_gnt", {30'd0, gnt_o}, 32'd1);
        check("push_pop_rvalid", {30'd0, rvalid_o}, 32'd1);
        resp_en = 1'b0;
        step(); req_i = 2'b00;
        @(negedge clk);
        check("push_pop_occ", {29'd0, outstanding_o}, 32'd2);
        resp_en = 1'b1;
        repeat (4) step();

        // Response with nothing outstanding.
        @(negedge clk);
        check("empty_occ", {29'd0, outstanding_o}, 32'd0);
        inject_rv = 1'b1;
        step(); @(negedge clk);
        check("stray_rvalid", {30'd0, rvalid_o}, 32'd0);
        inject_rv = 1'b0;
        step(); @(negedge clk);
        check("sticky_set", {31'd0, unexpected_rvalid_o}, 32'd1);
        repeat (3) step();
        @(negedge clk);
        check("sticky_hold", {31'd0, unexpected_rvalid_o}, 32'd1);

        // Reset with 3 outstanding; rr_ptr is left at 1 beforehand.
        resp_en = 1'b0;
        step(); req_i = 2'b01; out_gnt_i = 1'b1;
        repeat (3) step();
        req_i = 2'b00;
        @(negedge clk);
        check("pre_rst_occ", {29'd0, outstanding_o}, 32'd3);
        step(); reset = 1'b1; req_i = 2'b11; pend_q.delete();
        @(negedge clk);
        check("in_rst_gnt", {30'd0, gnt_o}, 32'd0);
        check("in_rst_out_req", {31'd0, out_req_o}, 32'd0);
        step(); reset = 1'b0; expect_resp(2'b01, D0);
        @(negedge clk);
        check("post_rst_occ", {29'd0, outstanding_o}, 32'd0);
        check("post_rst_sticky", {31'd0, unexpected_rvalid_o}, 32'd0);
        check("post_rst_gnt", {30'd0, gnt_o}, 32'd1);
        resp_en = 1'b1;
        step(); req_i = 2'b00; out_gnt_i = 1'b0;
        repeat (4) step();

        check("sb_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ibex_mem_intf_arbiter.md
Name: ibex_mem_intf_arbiter

Overview:
- Shares one downstream memory port between NUM_REQ upstream requesters, using the request/grant/rvalid protocol with integrity bits.
- Handles arbitration, holds the selection while a request waits for grant, and tracks outstanding transactions.
- Routes in-order responses back to the requester that issued each transaction.
- Sits between several memory agents (e.g. instr/data) and a single memory model or response driver in the DV environment.

Parameters:
- NUM_REQ, 2, number of upstream requesters (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- INTG_WIDTH, 7, integrity width for wdata and rdata.
- MAX_OUTSTANDING, 4, owner-FIFO depth, i.e. maximum granted-but-unanswered transactions (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_i  in  NUM_REQ  per-requester request.
- gnt_o  out  NUM_REQ  per-requester grant.
- addr_i  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester k occupies slice k.
- we_i  in  NUM_REQ  write enables.
- be_i  in  NUM_REQ*DATA_WIDTH/8  byte enables.
- wdata_i  in  NUM_REQ*DATA_WIDTH  write data.
- wintg_i  in  NUM_REQ*INTG_WIDTH  write integrity.
- rvalid_o  out  NUM_REQ  per-requester response valid.
- rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters.
- rintg_o  out  INTG_WIDTH  response integrity, broadcast.
- error_o  out  1  response error, broadcast.
- out_req_o  out  1  downstream request.
- out_gnt_i  in  1  downstream grant.
- out_addr_o  out  ADDR_WIDTH  downstream address.
- out_we_o  out  1  downstream write enable.
- out_be_o  out  DATA_WIDTH/8  downstream byte enable.
- out_wdata_o  out  DATA_WIDTH  downstream write data.
- out_wintg_o  out  INTG_WIDTH  downstream write integrity.
- out_rvalid_i  in  1  downstream response valid.
- out_rdata_i  in  DATA_WIDTH  downstream response data.
- out_rintg_i  in  INTG_WIDTH  downstream response integrity.
- out_error_i  in  1  downstream response error.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current owner-FIFO occupancy.
- unexpected_rvalid_o  out  1  sticky flag: out_rvalid_i seen while the owner FIFO was empty.

Behaviour:
- Reset:
  - All outputs 0.
  - Owner FIFO emptied.
  - Round-robin pointer = 0.
  - Lock cleared.
  - Sticky flag cleared.
  - In-flight responses are discarded; the downstream must be reset in the same cycle.
- Arbitration is combinational, zero added latency.
  - Winner w = first asserted req_i at or after rr_ptr, searching upward and wrapping.
  - When locked, w = lock_id.
- out_req_o = req_i[w] & ~fifo_full.
  - While the FIFO is full, out_req_o stays 0 even if a pop occurs in the same cycle.
- Downstream request fields are muxed from slice w. They are 0 when out_req_o = 0.
- gnt_o[w] = out_req_o & out_gnt_i. All other gnt_o bits are 0.
- Lock:
  - Set when out_req_o & ~out_gnt_i, with lock_id = w.
  - Cleared on a grant.
  - Cleared if req_i[lock_id] drops; this is a protocol violation, and the request is withdrawn.
  - A locked selection never switches requester until granted, so addr/we/be/wdata stay stable downstream.
- On grant:
  - Push w into the owner FIFO.
  - rr_ptr becomes (w+1) mod NUM_REQ on the next cycle.
  - rr_ptr is unchanged when there is no grant.
- On out_rvalid_i with the FIFO non-empty:
  - rvalid_o[head] = 1 in the same cycle.
  - Pop the head.
  - rdata_o/rintg_o/error_o pass through combinationally.
- On out_rvalid_i with the FIFO empty:
  - No rvalid_o bit is asserted.
  - unexpected_rvalid_o is set and stays set until reset.
- Simultaneous grant and rvalid in the same cycle: push and pop both occur, occupancy is unchanged, and the ordering holds.
- A response may arrive the cycle after its grant, but never in the grant cycle itself: the push is registered.
- FIFO pointers wrap modulo MAX_OUTSTANDING. outstanding_o is registered and updates one cycle after the push/pop.

Optional Feature:
- Macro: IBEX_MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index asserted req_i wins. rr_ptr is not implemented. Locking is unchanged.
- Undefined: round-robin as described above.

Test Plan:
- Both requesters hold req_i = 2'b11 and the downstream grants every cycle → grants alternate 0,1,0,1; rvalid_o is returned in matching order; rdata_o equals the memory content for each address.
- Requester 1 requests alone, out_gnt_i is low for 3 cycles, and requester 0 asserts in cycle 1 → out_addr_o stays at requester 1's address for all 3 cycles; gnt_o = 2'b10 on the grant; requester 0 is served next.
- MAX_OUTSTANDING = 4 with responses withheld → after 4 grants, out_req_o = 0 and outstanding_o = 4; the first rvalid gives outstanding_o = 3 one cycle later, and requests resume the following cycle.
- Grant and rvalid in the same cycle at occupancy 2 → occupancy stays 2, and the response is routed to the oldest owner.
- out_rvalid_i pulsed with the FIFO empty → no rvalid_o bit asserted; unexpected_rvalid_o = 1 until reset.
- reset asserted with 3 transactions outstanding → next cycle: outstanding_o = 0, gnt_o = 0, rr_ptr = 0, and the first post-reset grant goes to requester 0.
